// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped countdown timer sourcing one CP0 HWInt line.
// Define TIMER_IRQ_STATUS_EN to expose the STATUS register at offset 0xC.
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 2;

    localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_PRESET = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_COUNT  = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t              state;
    logic                ctrl_en;
    logic [1:0]          ctrl_mode;
    logic                ctrl_im;
    logic [DATA_W-1:0]   preset;
    logic [DATA_W-1:0]   count;
    logic                pending;

    logic                in_range;
    logic [OFF_W-1:0]    offset;
    logic                wr_ctrl;
    logic                wr_preset;
    logic                wr_status_clr;
    logic                pending_clr;
    logic                unused_addr_bits;

    // Block decodes a 16-byte window; byte lanes within a word are ignored.
    assign in_range         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset           = addr[3:2];
    assign unused_addr_bits = ^addr[1:0];

    assign wr_ctrl   = we && in_range && (offset == OFF_CTRL);
    assign wr_preset = we && in_range && (offset == OFF_PRESET);

`ifdef TIMER_IRQ_STATUS_EN
    assign wr_status_clr = we && in_range && (offset == OFF_STATUS) && wdata[0];
`else
    assign wr_status_clr = 1'b0;
`endif

    // Any CP0 handler ack path drops the pending flag.
    assign pending_clr = wr_ctrl || wr_preset || wr_status_clr;

    // Register file and countdown FSM; FSM assignments come last so an
    // expiry in the same cycle wins over a bus clear of pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            pending   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[0];
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end
            if (wr_preset) begin
                preset <= wdata;
            end
            if (pending_clr) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ctrl_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state <= IDLE;
                    end else if (count > DATA_W'(1)) begin
                        count <= count - DATA_W'(1);
                    end else begin
                        // PRESET of 0 lands here too, so COUNT never wraps.
                        count   <= '0;
                        pending <= 1'b1;
                        state   <= INT;
                    end
                end
                INT: begin
                    if (ctrl_mode == 2'b01) begin
                        pending <= 1'b0;
                    end else if (!wr_ctrl) begin
                        ctrl_en <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational read mux; out-of-range reads return zero.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            case (offset)
                OFF_CTRL:   rdata = DATA_W'({ctrl_im, ctrl_mode, ctrl_en});
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
`ifdef TIMER_IRQ_STATUS_EN
                OFF_STATUS: rdata = DATA_W'({state, pending});
`else
                OFF_STATUS: rdata = '0;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = pending && ctrl_im;

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: register-map vector table, directed
// corner sequences and randomized runs against a closed-form timing model.
module tb_timer_irq_source;
    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_irq_source #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, 32'(irq), 32'(exp));
    endtask

    // Reset, program PRESET, then write CTRL; the CTRL write edge is edge 0.
    task automatic restart(input logic [31:0] p, input logic [31:0] c);
        we    = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_write(A_PRESET, p);
        bus_write(A_CTRL, c);
    endtask

    // Expected state t edges after the enabling CTRL write, from the timing rules.
    task automatic model(input int t, input int p, input int mode, input int im,
                         output logic e_irq, output logic [31:0] e_cnt, output logic [31:0] e_ctrl);
        int  l;
        int  q;
        int  c;
        logic pend;
        logic en;
        l = (p < 1) ? 1 : p;
        if (mode == 1) begin
            q    = t % (l + 3);
            pend = (q == l + 2);
            c    = (q >= 2) ? p - (q - 2) : 0;
            en   = 1'b1;
        end else begin
            pend = (t >= l + 2);
            c    = (t >= 2) ? p - (t - 2) : 0;
            en   = (t < l + 3);
        end
        if (c < 0) c = 0;
        e_irq  = pend & (im != 0);
        e_cnt  = 32'(c);
        e_ctrl = 32'({im[0], mode[1:0], en});
    endtask

    task automatic seq_oneshot();
        int exp_c[5] = '{0, 3, 2, 1, 0};
        restart(32'd3, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_rd("oneshot_count", A_COUNT, 32'(exp_c[k-1]));
            chk_irq("oneshot_irq", k == 5);
        end
        for (int k = 6; k <= 9; k++) begin
            step();
            chk_irq("oneshot_irq_hold", 1'b1);
        end
        chk_rd("oneshot_ctrl_en_cleared", A_CTRL, 32'h8);
        bus_write(A_CTRL, 32'h0);
        chk_irq("oneshot_ack_ctrl", 1'b0);
    endtask

    task automatic seq_periodic();
        restart(32'd3, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk_irq("periodic_irq", (k == 5) || (k == 11) || (k == 17));
        end
        chk_rd("periodic_ctrl", A_CTRL, 32'hB);
    endtask

    task automatic seq_preset_zero();
        restart(32'd0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_irq("preset0_irq", k >= 3);
            chk_rd("preset0_count", A_COUNT, 32'd0);
        end
    endtask

    task automatic seq_midcount();
        restart(32'd8, 32'h9);
        for (int k = 1; k <= 5; k++) step();
        chk_rd("mid_count5", A_COUNT, 32'd5);
        bus_write(A_CTRL, 32'h8);
        chk_rd("mid_disable_edge", A_COUNT, 32'd4);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_rd("mid_frozen", A_COUNT, 32'd4);
            chk_irq("mid_irq_low", 1'b0);
        end
        // PRESET rewrite mid-count leaves the running countdown alone.
        restart(32'd3, 32'h9);
        step();
        step();
        bus_write(A_PRESET, 32'd7);
        chk_rd("preset_mid_count2", A_COUNT, 32'd2);
        step();
        chk_rd("preset_mid_count1", A_COUNT, 32'd1);
        chk_irq("preset_mid_irq_low", 1'b0);
        step();
        chk_irq("preset_mid_irq", 1'b1);
        chk_rd("preset_mid_readback", A_PRESET, 32'd7);
        bus_write(A_PRESET, 32'd7);
        chk_irq("preset_write_ack", 1'b0);
    endtask

    task automatic seq_races();
        // IM=0 expiry, with an IM=1 CTRL write on the expiry edge: set wins.
        restart(32'd2, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_irq("im0_irq_low", 1'b0);
        end
        bus_write(A_CTRL, 32'h9);
        chk_irq("set_beats_clear", 1'b1);
        // CTRL write in INT keeps EN and restarts the countdown.
        restart(32'd2, 32'h9);
        for (int k = 1; k <= 4; k++) step();
        chk_irq("int_irq", 1'b1);
        bus_write(A_CTRL, 32'h9);
        chk_rd("ctrl_beats_int", A_CTRL, 32'h9);
        chk_irq("int_ctrl_ack", 1'b0);
        step();
        step();
        chk_rd("reload_count", A_COUNT, 32'd2);
        step();
        step();
        chk_irq("reload_irq", 1'b1);
    endtask

    task automatic seq_status();
`ifdef TIMER_IRQ_STATUS_EN
        restart(32'd2, 32'h1);
        for (int k = 1; k <= 4; k++) step();
        chk_irq("status_im0_irq", 1'b0);
        chk_rd("status_int", A_STATUS, 32'h7);
        step();
        chk_rd("status_idle_pending", A_STATUS, 32'h1);
        bus_write(A_STATUS, 32'h0);
        chk_rd("status_write0_noclr", A_STATUS, 32'h1);
        bus_write(A_STATUS, 32'h1);
        chk_rd("status_clr", A_STATUS, 32'h0);
        restart(32'd2, 32'h9);
        for (int k = 1; k <= 3; k++) step();
        bus_write(A_STATUS, 32'h1);
        chk_irq("status_set_wins", 1'b1);
        step();
        bus_write(A_STATUS, 32'h1);
        chk_irq("status_ack", 1'b0);
`else
        restart(32'd2, 32'h9);
        for (int k = 1; k <= 5; k++) step();
        bus_write(A_STATUS, 32'h1);
        chk_irq("status_write_ignored", 1'b1);
        chk_rd("status_reads_zero", A_STATUS, 32'h0);
`endif
    endtask

    task automatic seq_reset_mid();
        restart(32'd5, 32'h9);
        for (int k = 1; k <= 3; k++) step();
        addr  = A_CTRL;
        wdata = 32'hF;
        we    = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        we    = 1'b0;
        chk_rd("rst_ctrl", A_CTRL, 32'h0);
        chk_rd("rst_preset", A_PRESET, 32'h0);
        chk_rd("rst_count", A_COUNT, 32'h0);
        chk_irq("rst_irq", 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_rd("rst_count_hold", A_COUNT, 32'h0);
        end
`ifdef TIMER_IRQ_STATUS_EN
        chk_rd("rst_status", A_STATUS, 32'h0);
`endif
    endtask

    task automatic seq_random();
        int   p, mode, im, l, n;
        logic e_irq;
        logic [31:0] e_cnt, e_ctrl;
        for (int trial = 0; trial < 30; trial++) begin
            p    = int'($urandom_range(0, 5));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            l    = (p < 1) ? 1 : p;
            n    = 3 * (l + 3) + 2;
            restart(32'(p), 32'({im[0], mode[1:0], 1'b1}));
            for (int t = 1; t <= n; t++) begin
                if ($urandom_range(0, 7) == 0)
                    bus_write(($urandom_range(0, 1) == 0) ? A_COUNT : BASE + 32'h10, $urandom);
                else
                    step();
                model(t, p, mode, im, e_irq, e_cnt, e_ctrl);
                chk_irq("rand_irq", e_irq);
                chk_rd("rand_count", A_COUNT, e_cnt);
                chk_rd("rand_ctrl", A_CTRL, e_ctrl);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, A_CTRL,           32'h0,          32'h0,          1'b0};
        vecs[1]  = '{1'b0, A_PRESET,         32'h0,          32'h0,          1'b0};
        vecs[2]  = '{1'b0, A_COUNT,          32'h0,          32'h0,          1'b0};
        vecs[3]  = '{1'b0, A_STATUS,         32'h0,          32'h0,          1'b0};
        vecs[4]  = '{1'b1, A_PRESET,         32'h1234_5678,  32'h1234_5678,  1'b0};
        vecs[5]  = '{1'b1, A_COUNT,          32'hFFFF_FFFF,  32'h0,          1'b0};
        vecs[6]  = '{1'b1, BASE + 32'h14,    32'hDEAD_BEEF,  32'h0,          1'b0};
        vecs[7]  = '{1'b0, A_PRESET,         32'h0,          32'h1234_5678,  1'b0};
        vecs[8]  = '{1'b1, A_CTRL,           32'hFFFF_FFF6,  32'h6,          1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0F00,    32'h9,          32'h0,          1'b0};
        vecs[10] = '{1'b0, A_CTRL,           32'h0,          32'h6,          1'b0};
        vecs[11] = '{1'b1, A_CTRL,           32'h0,          32'h0,          1'b0};

        reset = 1'b1;
        we    = 1'b0;
        addr  = A_CTRL;
        wdata = 32'h0;
        step();
        step();
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step();
            chk_irq("reset_idle_irq", 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
            else step();
            chk_rd("vec_rdata", vecs[i].a, vecs[i].exp_rd);
            chk_irq("vec_irq", vecs[i].exp_irq);
        end

        seq_oneshot();
        seq_periodic();
        seq_preset_zero();
        seq_midcount();
        seq_races();
        seq_status();
        seq_reset_mid();
        seq_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
